// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 16-bit MIPS pipeline.
// It tracks in-flight destination registers for the post-decode stages and
// produces operand forwarding selects, load-use and multi-cycle stalls, and
// a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 2,
  parameter int MC_CYCLES  = 4,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_uses_ra,
  input  logic              id_uses_rb,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              flush,
  output logic [SEL_W-1:0]  mux_sel_a,
  output logic [SEL_W-1:0]  mux_sel_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } entry_t;

  typedef enum logic {RUN, BUSY} state_t;

  localparam int             MC_W    = $clog2(MC_CYCLES) + 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_CYCLES - 1);
  localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);

  entry_t             stg     [1:NUM_STAGES];
  entry_t             stg_nxt [1:NUM_STAGES];
  state_t             state, state_nxt;
  logic [MC_W-1:0]    mc_cnt, mc_cnt_nxt;
  logic [SEL_W-1:0]   sel_a_raw, sel_b_raw;
  logic               ld_a, ld_b;
  logic               load_use;
  logic               busy;

  function automatic logic is_writer(input entry_t e);
    return e.v && e.we && (e.rd != '0);
  endfunction

  assign busy = (state == BUSY);

  // Youngest matching writer per source; load-use hazard from that writer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    sel_a_raw = '0;
    sel_b_raw = '0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    // Walk oldest to youngest so the lowest stage index overrides.
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (is_writer(stg[k]) && id_uses_ra && (id_ra != '0) && (stg[k].rd == id_ra)) begin
        sel_a_raw = SEL_W'(k);
        ld_a      = stg[k].ld;
      end
      if (is_writer(stg[k]) && id_uses_rb && (id_rb != '0) && (stg[k].rd == id_rb)) begin
        sel_b_raw = SEL_W'(k);
        ld_b      = stg[k].ld;
      end
    end
    load_use = ((sel_a_raw != '0) && (int'(sel_a_raw) < LOAD_READY) && ld_a) ||
               ((sel_b_raw != '0) && (int'(sel_b_raw) < LOAD_READY) && ld_b);
  end

  // A multi-cycle op still occupying EX has no result yet, so stage 1 is not a source.
  assign mux_sel_a = (busy && sel_a_raw == SEL_W'(1)) ? '0 : sel_a_raw;
  assign mux_sel_b = (busy && sel_b_raw == SEL_W'(1)) ? '0 : sel_b_raw;

  assign stall = (id_valid && load_use && !flush) || busy;

  // Next state for the RUN/BUSY FSM, the EX occupancy counter and the stage entries.
  always_comb begin
    state_nxt  = state;
    mc_cnt_nxt = mc_cnt;
    stg_nxt    = stg;
    case (state)
      RUN: begin
        if (stall) begin
          stg_nxt[1] = '0;
        end else begin
          stg_nxt[1] = entry_t'{v: id_valid && !flush, rd: id_rd, we: id_we, ld: id_is_load};
        end
        if (id_valid && id_is_mc && !stall && !flush) begin
          state_nxt  = BUSY;
          mc_cnt_nxt = MC_LOAD;
        end
      end
      BUSY: begin
        // Stage 1 keeps the multi-cycle op; flush cannot abort it.
        mc_cnt_nxt = mc_cnt - MC_ONE;
        if (mc_cnt == MC_ONE) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    for (int k = 2; k <= NUM_STAGES; k++) begin
      stg_nxt[k] = (k == 2 && busy) ? '0 : stg[k-1];
    end
  end

  // State, counter and stage-entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state  <= RUN;
      mc_cnt <= '0;
      // NOTE: the stage entries are a few flops, not a RAM, so clearing them on reset is cheap and required.
      for (int k = 1; k <= NUM_STAGES; k++) stg[k] <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
      for (int k = 1; k <= NUM_STAGES; k++) stg[k] <= stg_nxt[k];
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: hand-derived expectations are
// queued as each decode cycle is driven and compared at the following negedge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_ra, id_uses_rb, id_we, id_is_load, id_is_mc, flush;
  logic [4:0] id_ra, id_rb, id_rd;
  logic [1:0] mux_sel_a, mux_sel_b, sat_sel_a, sat_sel_b;
  logic       stall, sat_stall;
  logic [15:0] stall_count;
  logic [3:0]  sat_count;

  typedef struct {
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       stall;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .flush(flush),
    .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .stall(stall), .stall_count(stall_count)
  );

  // Narrow counter and a 20-cycle multi-cycle op to exercise saturation.
  pipe_hazard_ctrl #(.CNT_W(4), .MC_CYCLES(21)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .flush(flush),
    .mux_sel_a(sat_sel_a), .mux_sel_b(sat_sel_b), .stall(sat_stall), .stall_count(sat_count)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One decode cycle: drive inputs, queue the expectation, compare at negedge.
  task automatic step(input logic rst, input logic vld,
                      input logic [4:0] ra, input logic ua,
                      input logic [4:0] rb, input logic ub,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic mc, input logic fl,
                      input logic [1:0] ea, input logic [1:0] eb, input logic es);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = vld; id_ra = ra; id_uses_ra = ua; id_rb = rb; id_uses_rb = ub;
    id_rd = rd; id_we = we; id_is_load = ld; id_is_mc = mc; flush = fl;
    sb.push_back('{sel_a: ea, sel_b: eb, stall: es, cnt: exp_cnt});
    @(negedge clk);
    e = sb.pop_front();
    check("sel_a", int'(mux_sel_a), int'(e.sel_a));
    check("sel_b", int'(mux_sel_b), int'(e.sel_b));
    check("stall", int'(stall), int'(e.stall));
    check("stall_count", int'(stall_count), e.cnt);
    if (rst) exp_cnt = 0;
    else if (es) exp_cnt++;
  endtask

  task automatic nop();
    step(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_valid = 0; id_ra = 0; id_rb = 0; id_uses_ra = 0; id_uses_rb = 0;
    id_rd = 0; id_we = 0; id_is_load = 0; id_is_mc = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    nop();

    // Back-to-back ALU dependency and aging through stages 2 and 3.
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0); // add r3
    step(0, 1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0, 0, 2'd1, 2'd1, 0); // add r4,r3,r3
    step(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd2, 2'd0, 0);
    step(0, 1, 5'd3, 1, 5'd4, 1, 5'd0, 0, 0, 0, 0, 2'd3, 2'd2, 0);
    step(0, 1, 5'd3, 1, 5'd4, 1, 5'd0, 0, 0, 0, 0, 2'd0, 2'd3, 0);

    // Load-use: one stall, bubble, then forward from stage 2.
    step(0, 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'd0, 2'd0, 0); // lw r5
    step(0, 1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 2'd1, 2'd0, 1);
    step(0, 1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 2'd2, 2'd0, 0);
    nop();

    // Multiply: three BUSY stalls, then forward from the held stage 1.
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0, 2'd0, 2'd0, 0); // mul r6
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'd0, 2'd0, 1);
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'd0, 2'd0, 1);
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'd0, 2'd0, 1);
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'd1, 2'd0, 0);
    nop();

    // r0 never matches; unused sources never forward.
    step(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 2'd0, 2'd0, 0); // write r0
    step(0, 1, 5'd0, 1, 5'd7, 0, 5'd7, 1, 0, 0, 0, 2'd0, 2'd0, 0); // write r7
    step(0, 1, 5'd0, 1, 5'd7, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    step(0, 1, 5'd7, 1, 5'd7, 0, 5'd0, 0, 0, 0, 0, 2'd2, 2'd0, 0);
    nop(); nop(); nop();

    // Flush with load-use: no stall, killed decode entry leaves a bubble.
    step(0, 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'd0, 2'd0, 0); // lw r5
    step(0, 1, 5'd5, 1, 5'd0, 0, 5'd10, 1, 0, 0, 1, 2'd1, 2'd0, 0);
    step(0, 1, 5'd10, 1, 5'd5, 1, 5'd0, 0, 0, 0, 0, 2'd0, 2'd2, 0);
    nop(); nop(); nop();

    // A flushed multi-cycle op never starts.
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1, 1, 2'd0, 2'd0, 0);
    nop();

    // Flush during BUSY does not shorten or extend the op.
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0, 2'd0, 2'd0, 0); // mul r6
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd11, 1, 0, 0, 1, 2'd0, 2'd0, 1);
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd11, 1, 0, 0, 1, 2'd0, 2'd0, 1);
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd11, 1, 0, 0, 0, 2'd0, 2'd0, 1);
    step(0, 1, 5'd6, 1, 5'd0, 0, 5'd11, 1, 0, 0, 0, 2'd1, 2'd0, 0);
    nop(); nop(); nop();

    // Reset while BUSY at mc_cnt=2 aborts immediately.
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0, 2'd0, 2'd0, 0); // mul r6
    step(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1);
    step(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1);
    step(0, 1, 5'd6, 1, 5'd6, 1, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

    // Saturation: the narrow-counter instance stalls 20 cycles on one op.
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1, 0, 2'd0, 2'd0, 0); // mul r6
    for (int i = 1; i <= 21; i++) begin
      step(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, (i <= 3));
      if (i == 11) check("sat_mid", int'(sat_count), 10);
    end
    check("sat_full", int'(sat_count), 15);
    check("sat_release", int'(sat_stall), 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the 16-bit MIPS pipeline. It sits between decode and the register-bank operand muxes. It tracks the destination register of every in-flight instruction across `NUM_STAGES` post-decode stages (EX, DM, WB by default). From that history it produces forwarding selects, load-use stalls and multi-cycle-execute stalls, and it keeps a saturating count of stall cycles.

## Interface
Parameters:
- `REG_AW`, 5: register address width. Register 0 is hard-wired zero and is never forwarded.
- `NUM_STAGES`, 3: tracked post-decode stages. Stage 1 is EX; the last stage is WB.
- `LOAD_READY`, 2: first stage at which load data can be forwarded. Range 1..`NUM_STAGES`.
- `MC_CYCLES`, 4: EX occupancy of a multi-cycle op. Must be 2 or more.
- `CNT_W`, 16: stall counter width.
- `SEL_W`, `$clog2(NUM_STAGES+1)`: derived; operand select width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: the decode-stage instruction is real.
- `id_ra`, `id_rb` in `REG_AW`: source register addresses.
- `id_uses_ra`, `id_uses_rb` in 1: the corresponding source is actually read.
- `id_rd` in `REG_AW`: destination register.
- `id_we` in 1: the instruction writes `id_rd`.
- `id_is_load` in 1: the instruction is a load.
- `id_is_mc` in 1: the instruction is a multi-cycle EX op (multiply/divide).
- `flush` in 1: taken jump or branch; kills the decode-stage instruction this cycle.
- `mux_sel_a`, `mux_sel_b` out `SEL_W`: 0 selects the register file; k selects the result of stage k.
- `stall` out 1: hold PC and decode this cycle.
- `stall_count` out `CNT_W`: number of cycles with `stall`=1, saturating.

## Operation
- Per-stage entry k (1..`NUM_STAGES`) holds {v, rd, we, ld}. A "writer" is an entry with v & we & rd≠0.
- Forwarding for source A (source B is identical):
  - If `id_uses_ra` is 0 or `id_ra` is 0, `mux_sel_a` = 0.
  - Otherwise `mux_sel_a` = the lowest k whose writer rd equals `id_ra`. The youngest writer wins.
  - If no writer matches, `mux_sel_a` = 0.
  - The selects are combinational from the decode inputs and the stage entries.
- Load-use hazard: a matched writer at stage k < `LOAD_READY` that has ld=1.
- MC hazard: FSM state is BUSY and a source matches the stage-1 rd.
  - This case is already covered by the BUSY stall; it is listed only for completeness.
- `stall` = (`id_valid` & load-use hazard & ~`flush`) | (state==BUSY).
- FSM has two states, RUN and BUSY, with a down-counter `mc_cnt`.
  - RUN → BUSY when an instruction with `id_valid` & `id_is_mc` & ~`stall` & ~`flush` is accepted. `mc_cnt` loads `MC_CYCLES`-1.
  - In BUSY, `mc_cnt` decrements every cycle.
  - BUSY → RUN when `mc_cnt` is 1 at the edge.
  - While BUSY, stage 1 holds its entry; it is not yet complete.
- Stage update at each edge:
  - RUN with ~`stall`: stage 1 ← {`id_valid` & ~`flush`, `id_rd`, `id_we`, `id_is_load`}.
  - RUN with `stall` (load-use): stage 1 ← bubble (v=0).
  - BUSY: stage 1 holds, and stage 2 ← bubble.
  - In all cases, stages ≥2 not forced to a bubble take the previous stage's entry (stage k ← stage k-1).
- Forwarding from stage 1 is suppressed while BUSY, because the result is not valid.
- `flush` never aborts a BUSY op, since that op is older than the flushed instruction. `flush` only kills the decode entry.
- `stall_count` increments on every cycle where `stall`=1. It saturates at all-ones.

## Timing
- Reset, synchronous: all entries v=0, state RUN, `mc_cnt`=0, `stall_count`=0.
  - One cycle after reset, with `id_valid`=0, `stall`=0, `mux_sel_a`=0 and `mux_sel_b`=0.
- Forward-select latency is 0 cycles: selects are combinational in the same cycle as decode.
- Entries move one stage per clock.
- Load-use stalls last exactly `LOAD_READY`-k cycles for a match at stage k; this is 1 cycle by default.
- A multi-cycle op asserts `stall` for `MC_CYCLES`-1 cycles after its issue edge.
- `reset` asserted mid-BUSY aborts immediately: state becomes RUN and all entries are cleared on that edge.
- A `flush` and a load-use hazard in the same cycle give `stall`=0, and a bubble enters stage 1.
- Two stages matching the same rd: the lower index wins.
- rd=0 never matches.

## Test plan
- Back-to-back ALU dependency. Issue add r3 (we), then add r4,r3,r3. Required: `mux_sel_a`=`mux_sel_b`=1 and `stall`=0. One cycle later, an r3 reader gets select 2; two cycles later, select 3.
- Load-use. Issue lw r5, then a reader of r5. Required: `stall`=1 for one cycle and a bubble in stage 1. The reader then gets `mux_sel_a`=2 and `stall_count` reads 1.
- Multiply. Issue mul r6 with id_is_mc=1. Required: `stall`=1 for 3 cycles, stage 1 holds rd=6, and stage 2 gets bubbles. A following reader of r6 gets select 1 after BUSY→RUN. `stall_count` increases by 3.
- r0 and unused sources. Writer rd=0 with reader ra=0, and a writer r7 with `id_uses_rb`=0 and rb=7. Required: both selects stay 0.
- Flush on hazard. A load-use hazard with `flush`=1. Required: `stall`=0 and the stage-1 entry has v=0. `flush` during BUSY leaves `mc_cnt` counting normally.
- Reset mid-BUSY, and saturation. Assert `reset` at `mc_cnt`=2: required `stall`=0 in the next cycle and all entries invalid. Separately, with `CNT_W`=4, hold a stall for 20 cycles: required `stall_count`=15.
